// File: rtl/fx2_async_fifo_port.sv
// Cycle-timed master for the CY7C68013 asynchronous slave-FIFO bus (EP2 read, EP6 write, PKTEND).
// Optional idle-timeout auto PKTEND is enabled by defining FX2_AUTO_PKTEND_EN.
module fx2_async_fifo_port #(
   parameter int ADDR_SETUP_CYC = 2,
   parameter int STROBE_CYC     = 3,
   parameter int RECOVER_CYC    = 4,
   parameter int IDLE_TIMEOUT   = 1024
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] fd_in,
   output logic [7:0] fd_out,
   output logic       fd_oe,
   input  logic       flag_ep2_empty_n,
   input  logic       flag_ep6_full_n,
   output logic       slrd_n,
   output logic       slwr_n,
   output logic       sloe_n,
   output logic       pktend_n,
   output logic [1:0] fifoadr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       tx_flush,
   output logic       busy
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_RD_SETUP   = 4'd1;
   localparam logic [3:0] S_RD_STROBE  = 4'd2;
   localparam logic [3:0] S_RD_RECOVER = 4'd3;
   localparam logic [3:0] S_WR_SETUP   = 4'd4;
   localparam logic [3:0] S_WR_STROBE  = 4'd5;
   localparam logic [3:0] S_WR_RECOVER = 4'd6;
   localparam logic [3:0] S_PK_SETUP   = 4'd7;
   localparam logic [3:0] S_PK_STROBE  = 4'd8;
   localparam logic [3:0] S_PK_RECOVER = 4'd9;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(ADDR_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_ep2_sync;
   logic [1:0]       r_ep6_sync;
   logic             r_slrd_n;
   logic             r_slwr_n;
   logic             r_sloe_n;
   logic             r_pktend_n;
   logic [1:0]       r_fifoadr;
   logic             r_fd_oe;
   logic [7:0]       r_fd_out;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_tx_ready;
   logic             r_busy;
   logic             r_flush_pend;
   logic             r_dirty;
   logic             r_rr;

   logic       w_rx_elig;
   logic       w_tx_elig;
   logic       w_fl_elig;
   logic [3:0] w_pick;
   logic [3:0] w_nxt;
   logic       w_enter;
   logic       w_rx_take;
   logic       w_in_wr;
   logic       w_auto;

   // Eligibility uses only synchronised flags; the holding register counts as free if it drains this cycle
   assign w_rx_elig = r_ep2_sync[1] && (!r_rx_valid || rx_ready);
   assign w_tx_elig = tx_valid && r_ep6_sync[1];
   assign w_fl_elig = r_flush_pend && r_dirty && r_ep6_sync[1];
   assign w_in_wr   = (r_state == S_WR_SETUP) || (r_state == S_WR_STROBE);
   assign w_rx_take = (r_state == S_RD_STROBE) && (r_cnt == STROBE_LAST);
   assign w_enter   = (w_nxt != r_state);

   always_comb begin
      w_pick = S_IDLE;
      if (w_fl_elig)
         w_pick = S_PK_SETUP;
      else if (w_rx_elig && w_tx_elig)
         w_pick = r_rr ? S_WR_SETUP : S_RD_SETUP;
      else if (w_rx_elig)
         w_pick = S_RD_SETUP;
      else if (w_tx_elig)
         w_pick = S_WR_SETUP;
   end

   // The last recovery cycle arbitrates directly so back-to-back bytes keep the 9-cycle period
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:       w_nxt = w_pick;
         S_RD_SETUP:   if (r_cnt == SETUP_LAST)   w_nxt = S_RD_STROBE;
         S_RD_STROBE:  if (r_cnt == STROBE_LAST)  w_nxt = S_RD_RECOVER;
         S_RD_RECOVER: if (r_cnt == RECOVER_LAST) w_nxt = w_pick;
         S_WR_SETUP:   if (r_cnt == SETUP_LAST)   w_nxt = S_WR_STROBE;
         S_WR_STROBE:  if (r_cnt == STROBE_LAST)  w_nxt = S_WR_RECOVER;
         S_WR_RECOVER: if (r_cnt == RECOVER_LAST) w_nxt = w_pick;
         S_PK_SETUP:   if (r_cnt == SETUP_LAST)   w_nxt = S_PK_STROBE;
         S_PK_STROBE:  if (r_cnt == STROBE_LAST)  w_nxt = S_PK_RECOVER;
         S_PK_RECOVER: if (r_cnt == RECOVER_LAST) w_nxt = w_pick;
         default:      w_nxt = S_IDLE;
      endcase
   end

`ifdef FX2_AUTO_PKTEND_EN
   logic [15:0] r_idle_cnt;

   assign w_auto = r_dirty && !tx_valid && (r_idle_cnt == 16'(IDLE_TIMEOUT - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_idle_cnt <= '0;
      else if (r_tx_ready || !r_pktend_n || !(r_dirty && !tx_valid) || w_auto)
         r_idle_cnt <= '0;
      else
         r_idle_cnt <= r_idle_cnt + 16'd1;
   end
`else
   assign w_auto = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ep2_sync <= 2'b00;
         r_ep6_sync <= 2'b00;
         r_rr       <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_ep2_sync <= {r_ep2_sync[0], flag_ep2_empty_n};
         r_ep6_sync <= {r_ep6_sync[0], flag_ep6_full_n};
         if (w_enter || (r_state == S_IDLE))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_enter && ((w_nxt == S_RD_SETUP) || (w_nxt == S_WR_SETUP)))
            r_rr <= ~r_rr;
      end
   end

   // Bus pins are registered from the next state so strobes leave the flops glitch-free
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_slrd_n   <= 1'b1;
         r_slwr_n   <= 1'b1;
         r_sloe_n   <= 1'b1;
         r_pktend_n <= 1'b1;
         r_fifoadr  <= 2'b00;
         r_fd_oe    <= 1'b0;
         r_fd_out   <= 8'h00;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_slrd_n   <= (w_nxt != S_RD_STROBE);
         r_slwr_n   <= (w_nxt != S_WR_STROBE);
         r_pktend_n <= (w_nxt != S_PK_STROBE);
         r_sloe_n   <= !((w_nxt == S_RD_SETUP) || (w_nxt == S_RD_STROBE));
         r_fifoadr  <= ((w_nxt >= S_WR_SETUP) && (w_nxt <= S_PK_RECOVER)) ? 2'b10 : 2'b00;
         r_fd_oe    <= (w_nxt == S_WR_SETUP) || (w_nxt == S_WR_STROBE) ||
                       ((w_nxt == S_WR_RECOVER) && (r_state != S_WR_RECOVER));
         r_tx_ready <= w_enter && (w_nxt == S_WR_SETUP);
         r_busy     <= (w_nxt != S_IDLE);
         if (w_enter && (w_nxt == S_WR_SETUP))
            r_fd_out <= tx_data;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
         r_flush_pend <= 1'b0;
         r_dirty      <= 1'b0;
      end else begin
         if (w_rx_take) begin
            r_rx_data  <= fd_in;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_enter && (w_nxt == S_PK_SETUP))
            r_dirty <= 1'b0;
         else if (w_enter && (w_nxt == S_WR_RECOVER))
            r_dirty <= 1'b1;
         // A flush with nothing written is dropped, except while a write is still on its way to dirty
         if (w_enter && (w_nxt == S_PK_SETUP))
            r_flush_pend <= 1'b0;
         else if (!r_dirty && !w_in_wr)
            r_flush_pend <= 1'b0;
         else if (tx_flush || w_auto)
            r_flush_pend <= 1'b1;
      end
   end

   assign slrd_n   = r_slrd_n;
   assign slwr_n   = r_slwr_n;
   assign sloe_n   = r_sloe_n;
   assign pktend_n = r_pktend_n;
   assign fifoadr  = r_fifoadr;
   assign fd_oe    = r_fd_oe;
   assign fd_out   = r_fd_out;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_ready = r_tx_ready;
   assign busy     = r_busy;

endmodule

// File: tb/tb_fx2_async_fifo_port.sv
// Directed bench for fx2_async_fifo_port: EP2/EP6 bus models, a strobe monitor and vector tables.
module tb_fx2_async_fifo_port;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] fd_in;
   logic [7:0] fd_out;
   logic       fd_oe;
   logic       flag_ep2_empty_n;
   logic       flag_ep6_full_n;
   logic       slrd_n, slwr_n, sloe_n, pktend_n;
   logic [1:0] fifoadr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_flush;
   logic       busy;

   fx2_async_fifo_port #(
      .ADDR_SETUP_CYC(2), .STROBE_CYC(3), .RECOVER_CYC(4), .IDLE_TIMEOUT(16)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
      .flag_ep2_empty_n(flag_ep2_empty_n), .flag_ep6_full_n(flag_ep6_full_n),
      .slrd_n(slrd_n), .slwr_n(slwr_n), .sloe_n(sloe_n), .pktend_n(pktend_n), .fifoadr(fifoadr),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush), .busy(busy)
   );

   always #10 sys_clk = ~sys_clk;

   // EP2 model: a byte queue that pops on the rising edge of slrd_n
   logic [7:0] ep2_mem [64];
   int ep2_wr = 0;
   int ep2_rd = 0;

   always_comb begin
      flag_ep2_empty_n = (ep2_wr != ep2_rd);
      fd_in = sloe_n ? 8'hEE : ep2_mem[ep2_rd[5:0]];
   end

   always @(posedge slrd_n) begin
      if (sys_rst_n && (ep2_rd != ep2_wr)) ep2_rd = ep2_rd + 1;
   end

   task automatic ep2_push(input logic [7:0] b);
      ep2_mem[ep2_wr[5:0]] = b;
      ep2_wr = ep2_wr + 1;
   endtask

   // Monitor sampled on the falling edge
   int cyc = 0;
   int rd_n = 0, wr_n = 0, pk_n = 0, rx_n = 0, op_n = 0, txr_n = 0;
   int rd_run = 0, wr_run = 0, pk_run = 0;
   int rd_bad = 0, wr_bad = 0, ovl_bad = 0;
   int wr_fall = 0;
   int rd_w [64];
   int rd_start [64];
   int wr_w [64];
   int pk_w [64];
   logic [7:0] ops [64];
   logic [7:0] ep6_mem [64];
   logic [7:0] rx_got [64];
   logic [7:0] wr_hold = 8'h00;
   logic prev_sloe_n = 1'b1;

   always @(negedge sys_clk) begin
      cyc = cyc + 1;
      if (fd_oe && !sloe_n) ovl_bad = ovl_bad + 1;
      if (!slrd_n) begin
         if (rd_run == 0) begin
            rd_start[rd_n[5:0]] = cyc;
            ops[op_n[5:0]] = 8'h52;
            op_n = op_n + 1;
            if (prev_sloe_n) rd_bad = rd_bad + 1;
         end
         if (sloe_n) rd_bad = rd_bad + 1;
         rd_run = rd_run + 1;
      end else if (rd_run != 0) begin
         rd_w[rd_n[5:0]] = rd_run;
         rd_n = rd_n + 1;
         rd_run = 0;
      end
      if (!slwr_n) begin
         if (wr_run == 0) begin
            wr_hold = fd_out;
            wr_fall = cyc;
            ops[op_n[5:0]] = 8'h57;
            op_n = op_n + 1;
         end
         if ((fd_out !== wr_hold) || !fd_oe) wr_bad = wr_bad + 1;
         wr_run = wr_run + 1;
      end else if (wr_run != 0) begin
         ep6_mem[wr_n[5:0]] = wr_hold;
         wr_w[wr_n[5:0]] = wr_run;
         wr_n = wr_n + 1;
         wr_run = 0;
      end
      if (!pktend_n) begin
         if (pk_run == 0) begin
            ops[op_n[5:0]] = 8'h50;
            op_n = op_n + 1;
         end
         pk_run = pk_run + 1;
      end else if (pk_run != 0) begin
         pk_w[pk_n[5:0]] = pk_run;
         pk_n = pk_n + 1;
         pk_run = 0;
      end
      if (rx_valid && rx_ready) begin
         rx_got[rx_n[5:0]] = rx_data;
         rx_n = rx_n + 1;
      end
      if (tx_ready) txr_n = txr_n + 1;
      prev_sloe_n = sloe_n;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_tx(input logic [7:0] b, output bit ok);
      tx_data = b;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      step(1);
      tx_valid = 1'b0;
   endtask

   typedef struct {
      bit         is_tx;
      logic [7:0] din;
      logic [7:0] exp;
      int         exp_w;
   } vec_t;

   vec_t vt [7];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      bit ok;
      int b_rx, b_rd, b_wr, b_pk, b_op, b_txr, b_bad, rel, k;

      vt[0] = '{1'b0, 8'h55, 8'h55, 3};
      vt[1] = '{1'b0, 8'hAA, 8'hAA, 3};
      vt[2] = '{1'b0, 8'h01, 8'h01, 3};
      vt[3] = '{1'b1, 8'h10, 8'h10, 3};
      vt[4] = '{1'b1, 8'h11, 8'h11, 3};
      vt[5] = '{1'b1, 8'h12, 8'h12, 3};
      vt[6] = '{1'b1, 8'h13, 8'h13, 3};

      rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_flush = 1'b0;
      flag_ep6_full_n = 1'b1; sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_slrd_n", slrd_n, 1);
      chk("rst_slwr_n", slwr_n, 1);
      chk("rst_sloe_n", sloe_n, 1);
      chk("rst_pktend_n", pktend_n, 1);
      chk("rst_fifoadr", fifoadr, 0);
      chk("rst_fd_oe", fd_oe, 0);
      chk("rst_fd_out", fd_out, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_busy", busy, 0);
      step(1);
      sys_rst_n = 1'b1;
      step(3);

      // Three EP2 bytes drained back to back
      rx_ready = 1'b1;
      b_rx = rx_n; b_rd = rd_n; b_bad = rd_bad;
      for (int i = 0; i < 7; i++) if (!vt[i].is_tx) ep2_push(vt[i].din);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if ((rx_n >= b_rx + 3) && (rd_n >= b_rd + 3)) begin ok = 1'b1; break; end
      end
      chk("rx3_timeout", ok, 1);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         if (!vt[i].is_tx) begin
            chk("rx_data_order", rx_got[(b_rx + k) % 64], vt[i].exp);
            chk("slrd_width", rd_w[(b_rd + k) % 64], vt[i].exp_w);
            if (k > 0) chk("slrd_period", rd_start[(b_rd + k) % 64] - rd_start[(b_rd + k - 1) % 64], 9);
            k = k + 1;
         end
      end
      chk("sloe_around_strobe", rd_bad - b_bad, 0);
      step(30);
      chk("rd_count_empty", rd_n - b_rd, 3);

      // Backpressure on the holding register
      rx_ready = 1'b0;
      b_rx = rx_n; b_rd = rd_n;
      ep2_push(8'h21); ep2_push(8'h22);
      step(40);
      chk("hold_one_read", rd_n - b_rd, 1);
      chk("hold_rx_valid", rx_valid, 1);
      chk("hold_rx_data", rx_data, 8'h21);
      rx_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (rx_n >= b_rx + 2) begin ok = 1'b1; break; end
      end
      chk("hold_release_timeout", ok, 1);
      chk("hold_rx0", rx_got[b_rx % 64], 8'h21);
      chk("hold_rx1", rx_got[(b_rx + 1) % 64], 8'h22);
      step(20);
      chk("hold_two_reads", rd_n - b_rd, 2);

      // Four EP6 writes, a flush, then a flush with nothing pending
      b_wr = wr_n; b_pk = pk_n; b_bad = wr_bad;
      for (int i = 0; i < 7; i++) begin
         if (vt[i].is_tx) begin
            send_tx(vt[i].din, ok);
            chk("tx_accept", ok, 1);
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (wr_n >= b_wr + 4) begin ok = 1'b1; break; end
      end
      chk("wr4_timeout", ok, 1);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         if (vt[i].is_tx) begin
            chk("ep6_byte", ep6_mem[(b_wr + k) % 64], vt[i].exp);
            chk("slwr_width", wr_w[(b_wr + k) % 64], vt[i].exp_w);
            k = k + 1;
         end
      end
      chk("fd_stable_oe", wr_bad - b_bad, 0);
      step(1);
      tx_flush = 1'b1; step(1); tx_flush = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (pk_n >= b_pk + 1) begin ok = 1'b1; break; end
      end
      chk("pktend_timeout", ok, 1);
      chk("pktend_width", pk_w[b_pk % 64], 3);
      step(10);
      tx_flush = 1'b1; step(1); tx_flush = 1'b0;
      step(40);
      chk("flush_clean_no_pkt", pk_n - b_pk, 1);

      // EP6 full blocks the write but not reads
      flag_ep6_full_n = 1'b0;
      step(4);
      b_wr = wr_n; b_txr = txr_n; b_rx = rx_n;
      tx_data = 8'h77; tx_valid = 1'b1;
      ep2_push(8'h33);
      step(40);
      chk("full_no_write", wr_n - b_wr, 0);
      chk("full_no_tx_ready", txr_n - b_txr, 0);
      chk("full_rx_count", rx_n - b_rx, 1);
      chk("full_rx_byte", rx_got[b_rx % 64], 8'h33);
      flag_ep6_full_n = 1'b1;
      rel = cyc;
      send_tx(8'h77, ok);
      chk("full_release_accept", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         if (wr_n >= b_wr + 1) begin ok = 1'b1; break; end
      end
      chk("full_release_timeout", ok, 1);
      chk("full_release_latency", (wr_fall - rel) <= 7, 1);
      chk("full_release_byte", ep6_mem[b_wr % 64], 8'h77);

      // Contention after reset alternates read, write, read
      sys_rst_n = 1'b0;
      tx_data = 8'h51; tx_valid = 1'b1; rx_ready = 1'b1;
      ep2_push(8'h41); ep2_push(8'h42);
      step(2);
      b_op = op_n; b_txr = txr_n; b_rx = rx_n;
      sys_rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (txr_n > b_txr) begin ok = 1'b1; break; end
      end
      chk("rr_tx_accept", ok, 1);
      step(1);
      tx_valid = 1'b0;
      step(40);
      chk("rr_op_count", op_n - b_op, 3);
      chk("rr_op0_read", ops[b_op % 64], 8'h52);
      chk("rr_op1_write", ops[(b_op + 1) % 64], 8'h57);
      chk("rr_op2_read", ops[(b_op + 2) % 64], 8'h52);
      chk("rr_rx_second", rx_got[(b_rx + 1) % 64], 8'h42);

      // Reset in the middle of a read strobe
      b_rx = rx_n;
      ep2_push(8'h66);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (!slrd_n) begin ok = 1'b1; break; end
      end
      chk("rst_mid_reach_strobe", ok, 1);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_mid_slrd_n", slrd_n, 1);
      chk("rst_mid_sloe_n", sloe_n, 1);
      chk("rst_mid_rx_valid", rx_valid, 0);
      chk("rst_mid_busy", busy, 0);
      step(2);
      chk("rst_mid_no_delivery", rx_n - b_rx, 0);
      sys_rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (rx_n >= b_rx + 1) begin ok = 1'b1; break; end
      end
      chk("rst_mid_reread", ok, 1);
      chk("rst_mid_reread_byte", rx_got[b_rx % 64], 8'h66);

      // One byte then idle: auto PKTEND only when the feature is built in
      step(5);
      send_tx(8'h99, ok);
      chk("idle_tx_accept", ok, 1);
      b_pk = pk_n;
      step(80);
`ifdef FX2_AUTO_PKTEND_EN
      chk("auto_pktend", pk_n - b_pk, 1);
`else
      chk("no_auto_pktend", pk_n - b_pk, 0);
`endif
      chk("no_oe_overlap", ovl_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
